// File: rtl/device_decoder_if.sv
// Upstream device request bus between the core-to-device arbiter (master)
// and the device decoder (slave). Signal names follow the decoder's view.
interface device_decoder_if #(
  parameter int XLEN = 32
);
  // Handshake: the master pulses DEVICE_strobe_i for one cycle with
  // addr/rw/byte_enable/data valid in that cycle, and issues no further
  // strobe until it has seen DEVICE_data_ready_o. DEVICE_data_ready_o is a
  // one-cycle pulse; DEVICE_data_o is meaningful only in that cycle.
  logic              DEVICE_strobe_i;
  logic [XLEN-1:0]   DEVICE_addr_i;
  logic              DEVICE_rw_i;
  logic [XLEN/8-1:0] DEVICE_byte_enable_i;
  logic [XLEN-1:0]   DEVICE_data_i;
  logic              DEVICE_data_ready_o;
  logic [XLEN-1:0]   DEVICE_data_o;

  modport master (
    output DEVICE_strobe_i, DEVICE_addr_i, DEVICE_rw_i,
           DEVICE_byte_enable_i, DEVICE_data_i,
    input  DEVICE_data_ready_o, DEVICE_data_o
  );

  modport slave (
    input  DEVICE_strobe_i, DEVICE_addr_i, DEVICE_rw_i,
           DEVICE_byte_enable_i, DEVICE_data_i,
    output DEVICE_data_ready_o, DEVICE_data_o
  );
endinterface

// File: rtl/device_decoder.sv
// Routes serialized device requests to N_DEV memory-mapped slaves, with
// error termination for unmapped addresses and slaves that never answer.
module device_decoder #(
  parameter int              XLEN     = 32,
  parameter int              N_DEV    = 4,
  parameter logic [7:0]      BASE_HI  = 8'hC0,
  parameter int              TIMEOUT  = 255,
  parameter logic [XLEN-1:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  device_decoder_if.slave       dev,
  output logic [N_DEV-1:0]      S_strobe_o,
  output logic [XLEN-1:0]       S_addr_o,
  output logic                  S_rw_o,
  output logic [XLEN/8-1:0]     S_byte_enable_o,
  output logic [XLEN-1:0]       S_data_o,
  input  logic [N_DEV-1:0]      S_data_ready_i,
  input  logic [N_DEV*XLEN-1:0] S_data_i,
  output logic                  err_o,
  output logic [XLEN-1:0]       err_addr_o,
  output logic [1:0]            state_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   addr_q, addr_d, wdata_q, wdata_d;
  logic              rw_q, rw_d;
  logic [XLEN/8-1:0] be_q, be_d;
  logic [7:0]        idx_q, idx_d;
  logic              mapped_q, mapped_d;
  logic              err_flag_q, err_flag_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [XLEN-1:0]   resp_q, resp_d, err_addr_q, err_addr_d;

  logic [7:0]        addr_hi, idx_in;
  logic              sel_ready;
  logic [XLEN-1:0]   sel_data;
  logic [N_DEV-1:0]  sel_onehot;

  assign addr_hi = dev.DEVICE_addr_i[XLEN-1 -: 8];
  assign idx_in  = addr_hi - BASE_HI;

  // Only the latched slave index is ever looked at; other slaves are invisible.
  always_comb begin
    sel_ready  = 1'b0;
    sel_data   = '0;
    sel_onehot = '0;
    for (int k = 0; k < N_DEV; k++) begin
      if (idx_q == 8'(k)) begin
        sel_ready     = S_data_ready_i[k];
        sel_data      = S_data_i[k*XLEN +: XLEN];
        sel_onehot[k] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rw_d       = rw_q;
    be_d       = be_q;
    idx_d      = idx_q;
    mapped_d   = mapped_q;
    err_flag_d = err_flag_q;
    cnt_d      = cnt_q;
    resp_d     = resp_q;
    err_addr_d = err_addr_q;
    unique case (state_q)
      IDLE: begin
        if (dev.DEVICE_strobe_i) begin
          addr_d     = dev.DEVICE_addr_i;
          wdata_d    = dev.DEVICE_data_i;
          rw_d       = dev.DEVICE_rw_i;
          be_d       = dev.DEVICE_byte_enable_i;
          idx_d      = idx_in;
          mapped_d   = (addr_hi >= BASE_HI) && (idx_in < 8'(N_DEV));
          err_flag_d = 1'b0;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d = '0;
        if (!mapped_q) begin
          resp_d     = rw_q ? '0 : ERR_DATA;
          err_flag_d = 1'b1;
          err_addr_d = addr_q;
          state_d    = RESP;
        end else if (sel_ready) begin
          // A slave may answer in the same cycle it sees its strobe.
          resp_d  = rw_q ? '0 : sel_data;
          state_d = RESP;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (sel_ready) begin
          resp_d  = rw_q ? '0 : sel_data;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
          if (cnt_d == 16'(TIMEOUT)) begin
            resp_d     = rw_q ? '0 : ERR_DATA;
            err_flag_d = 1'b1;
            err_addr_d = addr_q;
            state_d    = RESP;
          end
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      rw_q       <= 1'b0;
      be_q       <= '0;
      idx_q      <= '0;
      mapped_q   <= 1'b0;
      err_flag_q <= 1'b0;
      cnt_q      <= '0;
      resp_q     <= '0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rw_q       <= rw_d;
      be_q       <= be_d;
      idx_q      <= idx_d;
      mapped_q   <= mapped_d;
      err_flag_q <= err_flag_d;
      cnt_q      <= cnt_d;
      resp_q     <= resp_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign S_strobe_o              = (state_q == ISSUE && mapped_q) ? sel_onehot : '0;
  assign S_addr_o                = addr_q;
  assign S_rw_o                  = rw_q;
  assign S_byte_enable_o         = be_q;
  assign S_data_o                = wdata_q;
  assign dev.DEVICE_data_ready_o = (state_q == RESP);
  assign dev.DEVICE_data_o       = resp_q;
  assign err_o                   = (state_q == RESP) && err_flag_q;
  assign err_addr_o              = err_addr_q;
  assign state_o                 = state_q;

endmodule

// File: tb/tb_device_decoder.sv
// Directed bench for device_decoder: mapped reads/writes, unmapped and
// timeout errors, noise/busy strobes and mid-transaction reset.
module tb_device_decoder;
  localparam int XLEN  = 32;
  localparam int N_DEV = 4;
  localparam int TMO   = 8;

  logic                  clk;
  logic                  rst;
  logic [N_DEV-1:0]      s_strobe;
  logic [XLEN-1:0]       s_addr;
  logic                  s_rw;
  logic [XLEN/8-1:0]     s_be;
  logic [XLEN-1:0]       s_wdata;
  logic [N_DEV-1:0]      s_ready;
  logic [N_DEV*XLEN-1:0] s_rdata;
  logic                  err;
  logic [XLEN-1:0]       err_addr;
  logic [1:0]            state;

  int n_checks = 0;
  int n_pass   = 0;
  logic [XLEN-1:0] exp_q[$];

  device_decoder_if #(.XLEN(XLEN)) bus ();

  device_decoder #(.XLEN(XLEN), .N_DEV(N_DEV), .BASE_HI(8'hC0), .TIMEOUT(TMO),
                   .ERR_DATA(32'hDEAD_BEEF)) dut (
    .clk_i(clk), .rst_i(rst), .dev(bus),
    .S_strobe_o(s_strobe), .S_addr_o(s_addr), .S_rw_o(s_rw),
    .S_byte_enable_o(s_be), .S_data_o(s_wdata),
    .S_data_ready_i(s_ready), .S_data_i(s_rdata),
    .err_o(err), .err_addr_o(err_addr), .state_o(state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Observations gathered by the driver, checked by the test tasks.
  int              o_resp_cyc, o_n_resp, o_err_cnt, o_strobe_cnt, o_strobe_cyc;
  logic [XLEN-1:0] o_resp_data, o_err_addr, o_s_addr, o_s_wdata, o_s_addr_resp;
  logic [N_DEV-1:0]  o_strobe_or;
  logic [XLEN/8-1:0] o_s_be;
  logic            o_s_rw;

  // Enters aligned just after a posedge; cycle 0 carries the request strobe.
  task automatic drive_txn(input logic [XLEN-1:0] addr, input logic rw,
                           input logic [XLEN/8-1:0] be, input logic [XLEN-1:0] wdata,
                           input int rdy_slave, input int rdy_cyc,
                           input logic [XLEN-1:0] rdy_data,
                           input int noise_slave, input int noise_cyc,
                           input int busy_cyc, input int max_cyc);
    o_resp_cyc = -1; o_n_resp = 0; o_err_cnt = 0; o_strobe_cnt = 0;
    o_strobe_cyc = -1; o_strobe_or = '0; o_resp_data = 'x; o_err_addr = 'x;
    o_s_addr_resp = 'x;
    for (int cyc = 0; cyc <= max_cyc; cyc++) begin
      bus.DEVICE_strobe_i      = (cyc == 0) || (cyc == busy_cyc);
      bus.DEVICE_addr_i        = (cyc == busy_cyc) ? 32'hC000_0010 : addr;
      bus.DEVICE_rw_i          = (cyc == busy_cyc) ? 1'b1 : rw;
      bus.DEVICE_byte_enable_i = be;
      bus.DEVICE_data_i        = (cyc == busy_cyc) ? 32'h5555_5555 : wdata;
      s_ready = '0;
      for (int k = 0; k < N_DEV; k++) s_rdata[k*XLEN +: XLEN] = 32'hBAD0_0000 | k;
      if (rdy_slave >= 0) s_rdata[rdy_slave*XLEN +: XLEN] = rdy_data;
      if (cyc == rdy_cyc && rdy_slave >= 0) s_ready[rdy_slave] = 1'b1;
      if (cyc == noise_cyc) s_ready[noise_slave] = 1'b1;
      @(negedge clk);
      if (bus.DEVICE_data_ready_o) begin
        o_n_resp++;
        if (o_resp_cyc < 0) begin
          o_resp_cyc    = cyc;
          o_resp_data   = bus.DEVICE_data_o;
          o_err_addr    = err_addr;
          o_s_addr_resp = s_addr;
        end
      end
      if (err) o_err_cnt++;
      if (s_strobe != '0 && o_strobe_cyc < 0) o_strobe_cyc = cyc;
      o_strobe_or  |= s_strobe;
      o_strobe_cnt += $countones(s_strobe);
      if (cyc == 1) begin
        o_s_addr = s_addr; o_s_wdata = s_wdata; o_s_be = s_be; o_s_rw = s_rw;
      end
      @(posedge clk);
      #1;
    end
    bus.DEVICE_strobe_i = 1'b0;
    s_ready = '0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.DEVICE_strobe_i = 1'b0; bus.DEVICE_addr_i = '0; bus.DEVICE_rw_i = 1'b0;
    bus.DEVICE_byte_enable_i = '0; bus.DEVICE_data_i = '0;
    s_ready = '0; s_rdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus.DEVICE_data_ready_o, err, s_strobe, state} !== '0)
      $display("FAIL reset_ctrl: got rdy=%b err=%b strobe=%b state=%0d want all 0",
               bus.DEVICE_data_ready_o, err, s_strobe, state);
    else n_pass++;
    n_checks++;
    if ({bus.DEVICE_data_o, err_addr, s_addr, s_wdata, s_be, s_rw} !== '0)
      $display("FAIL reset_data: got data=%h err_addr=%h s_addr=%h s_wdata=%h want 0",
               bus.DEVICE_data_o, err_addr, s_addr, s_wdata);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_read_dev1;
    logic [XLEN-1:0] exp;
    exp_q.push_back(32'h1234_5678);
    drive_txn(32'hC100_0008, 1'b0, 4'hF, 32'h0, 1, 4, 32'h1234_5678, 0, -1, -1, 8);
    exp = exp_q.pop_front();
    n_checks++;
    if (o_strobe_or !== 4'b0010 || o_strobe_cnt != 1 || o_strobe_cyc != 1)
      $display("FAIL read1_strobe: got or=%b cnt=%0d cyc=%0d want 0010/1/1",
               o_strobe_or, o_strobe_cnt, o_strobe_cyc);
    else n_pass++;
    n_checks++;
    if (o_resp_cyc != 5 || o_n_resp != 1)
      $display("FAIL read1_latency: got cyc=%0d n=%0d want 5/1", o_resp_cyc, o_n_resp);
    else n_pass++;
    n_checks++;
    if (o_resp_data !== exp || o_err_cnt != 0)
      $display("FAIL read1_data: got %h err=%0d want %h err=0", o_resp_data, o_err_cnt, exp);
    else n_pass++;
  endtask

  task automatic test_write_dev0;
    drive_txn(32'hC000_0004, 1'b1, 4'b0001, 32'h41, 0, 1, 32'hFFFF_FFFF, 0, -1, -1, 5);
    n_checks++;
    if (o_s_addr !== 32'hC000_0004 || o_s_wdata !== 32'h41 || o_s_be !== 4'b0001 || o_s_rw !== 1'b1)
      $display("FAIL write0_bus: got addr=%h data=%h be=%b rw=%b want c0000004/41/0001/1",
               o_s_addr, o_s_wdata, o_s_be, o_s_rw);
    else n_pass++;
    n_checks++;
    if (o_resp_cyc != 2 || o_resp_data !== 32'h0 || o_strobe_or !== 4'b0001 || o_err_cnt != 0)
      $display("FAIL write0_resp: got cyc=%0d data=%h strobe=%b err=%0d want 2/0/0001/0",
               o_resp_cyc, o_resp_data, o_strobe_or, o_err_cnt);
    else n_pass++;
  endtask

  task automatic test_unmapped;
    logic [XLEN-1:0] addrs[2];
    addrs[0] = 32'hC800_0000;
    addrs[1] = 32'hB000_0000;
    for (int i = 0; i < 2; i++) begin
      drive_txn(addrs[i], 1'b0, 4'hF, 32'h0, -1, -1, 32'h0, 0, -1, -1, 5);
      n_checks++;
      if (o_strobe_cnt != 0 || o_resp_cyc != 2 || o_n_resp != 1)
        $display("FAIL unmapped_%0d_flow: strobes=%0d cyc=%0d n=%0d want 0/2/1",
                 i, o_strobe_cnt, o_resp_cyc, o_n_resp);
      else n_pass++;
      n_checks++;
      if (o_resp_data !== 32'hDEAD_BEEF || o_err_cnt != 1 || o_err_addr !== addrs[i])
        $display("FAIL unmapped_%0d_err: data=%h err=%0d err_addr=%h want deadbeef/1/%h",
                 i, o_resp_data, o_err_cnt, o_err_addr, addrs[i]);
      else n_pass++;
    end
    n_checks++;
    if (err_addr !== 32'hB000_0000)
      $display("FAIL err_addr_hold: got %h want b0000000", err_addr);
    else n_pass++;
  endtask

  task automatic test_timeout;
    drive_txn(32'hC200_0000, 1'b0, 4'hF, 32'h0, 2, TMO + 4, 32'h7777_7777, 0, -1, -1, TMO + 7);
    n_checks++;
    if (o_resp_cyc != TMO + 2 || o_n_resp != 1 || o_strobe_or !== 4'b0100)
      $display("FAIL timeout_flow: cyc=%0d n=%0d strobe=%b want %0d/1/0100",
               o_resp_cyc, o_n_resp, o_strobe_or, TMO + 2);
    else n_pass++;
    n_checks++;
    if (o_resp_data !== 32'hDEAD_BEEF || o_err_cnt != 1 || o_err_addr !== 32'hC200_0000)
      $display("FAIL timeout_err: data=%h err=%0d err_addr=%h want deadbeef/1/c2000000",
               o_resp_data, o_err_cnt, o_err_addr);
    else n_pass++;
    drive_txn(32'hC300_0020, 1'b0, 4'hF, 32'h0, 3, 2, 32'h0303_0303, 0, -1, -1, 6);
    n_checks++;
    if (o_resp_cyc != 3 || o_resp_data !== 32'h0303_0303 || o_err_cnt != 0 || o_n_resp != 1)
      $display("FAIL after_timeout: cyc=%0d data=%h err=%0d n=%0d want 3/03030303/0/1",
               o_resp_cyc, o_resp_data, o_err_cnt, o_n_resp);
    else n_pass++;
  endtask

  task automatic test_noise_busy;
    logic [XLEN-1:0] exp;
    exp_q.push_back(32'hA5A5_0003);
    drive_txn(32'hC300_0100, 1'b0, 4'hF, 32'h0, 3, 5, 32'hA5A5_0003, 0, 3, 2, 12);
    exp = exp_q.pop_front();
    n_checks++;
    if (o_n_resp != 1 || o_resp_cyc != 6 || o_strobe_cnt != 1 || o_strobe_or !== 4'b1000)
      $display("FAIL busy_flow: n=%0d cyc=%0d strobes=%0d or=%b want 1/6/1/1000",
               o_n_resp, o_resp_cyc, o_strobe_cnt, o_strobe_or);
    else n_pass++;
    n_checks++;
    if (o_resp_data !== exp || o_err_cnt != 0 || o_s_addr_resp !== 32'hC300_0100)
      $display("FAIL busy_data: data=%h err=%0d s_addr=%h want %h/0/c3000100",
               o_resp_data, o_err_cnt, o_s_addr_resp, exp);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    int resp_seen;
    drive_txn(32'hC100_0000, 1'b0, 4'hF, 32'h0, 1, -1, 32'h0, 0, -1, -1, 3);
    rst = 1'b1;
    @(negedge clk);
    resp_seen = bus.DEVICE_data_ready_o ? 1 : 0;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.DEVICE_data_ready_o || err) resp_seen++;
      if (c == 0) begin
        n_checks++;
        if ({state, s_strobe, bus.DEVICE_data_o, err_addr, s_addr} !== '0)
          $display("FAIL midreset_state: state=%0d strobe=%b data=%h err_addr=%h s_addr=%h want 0",
                   state, s_strobe, bus.DEVICE_data_o, err_addr, s_addr);
        else n_pass++;
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (resp_seen != 0)
      $display("FAIL midreset_noresp: got %0d responses want 0", resp_seen);
    else n_pass++;
    drive_txn(32'hC100_0004, 1'b0, 4'hF, 32'h0, 1, 2, 32'hCAFE_0001, 0, -1, -1, 5);
    n_checks++;
    if (o_resp_cyc != 3 || o_resp_data !== 32'hCAFE_0001 || o_strobe_cyc != 1)
      $display("FAIL post_reset_txn: cyc=%0d data=%h strobe_cyc=%0d want 3/cafe0001/1",
               o_resp_cyc, o_resp_data, o_strobe_cyc);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_read_dev1();
    test_write_dev0();
    test_unmapped();
    test_timeout();
    test_noise_busy();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
